// File: rtl/can_frame_receiver.sv
// CAN 2.0A receive path. Destuffs the sampled bit stream, parses standard data and remote
// frames, checks CRC-15 and fixed-form fields, drives the ACK slot, and reports a frame or an error.
module can_frame_receiver #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic        can_clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        can_hi_in,
  output logic        ack_out,
  output logic        rx_valid,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_err,
  output logic [2:0]  err_code,
  output logic        busy
);
  localparam int unsigned ID_W   = 11;
  localparam int unsigned DLC_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CRC_W  = 15;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned RUN_W  = 3;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;
  localparam logic [2:0] ERR_STUFF = 3'd1;
  localparam logic [2:0] ERR_CRC   = 3'd2;
  localparam logic [2:0] ERR_FORM  = 3'd3;
  localparam logic [2:0] ERR_IDE   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [RUN_W-1:0]    run_cnt, run_cnt_d;
  logic                run_lvl, run_lvl_d;
  logic [CRC_W-1:0]    crc, crc_d, crc_rx, crc_rx_d;
  logic                ack_d, rx_valid_d, rx_err_d, rx_rtr_d, busy_d;
  logic [2:0]          err_code_d;
  logic [ID_W-1:0]     rx_id_d;
  logic [DLC_W-1:0]    rx_dlc_d;
  logic [DATA_W-1:0]   rx_data_d;
  logic                bit_c, in_stuff_c, is_stuff_c, stuff_err_c, data_bit_c;
  logic                err_hit_c;
  logic [2:0]          err_kind_c;
  logic [CNT_W-1:0]    last_data_c;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    crc_step = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ d) ? CRC_POLY : CRC_W'(0));
  endfunction

  function automatic logic [DLC_W-1:0] byte_count(input logic rtr, input logic [DLC_W-1:0] dlc);
    if (rtr)                          byte_count = '0;
    else if (dlc > DLC_W'(MAX_BYTES)) byte_count = DLC_W'(MAX_BYTES);
    else                              byte_count = dlc;
  endfunction

  // Stuff bit expected once five equal bits are seen, including right after the last CRC bit.
  assign bit_c       = ~can_hi_in;
  assign in_stuff_c  = (state inside {S_ARB, S_CTRL, S_DATA, S_CRC}) ||
                       (state == S_CRC_DEL && run_cnt == RUN_W'(5));
  assign is_stuff_c  = sample_en && in_stuff_c && (run_cnt == RUN_W'(5));
  assign stuff_err_c = is_stuff_c && (bit_c == run_lvl);
  assign data_bit_c  = sample_en && !is_stuff_c;
  assign last_data_c = {byte_count(rx_rtr, rx_dlc), 3'b000} - CNT_W'(1);

  always_ff @(posedge can_clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run_cnt  <= '0;
      run_lvl  <= 1'b0;
      crc      <= '0;
      crc_rx   <= '0;
      ack_out  <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
      rx_id    <= '0;
      rx_rtr   <= 1'b0;
      rx_dlc   <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      run_cnt  <= run_cnt_d;
      run_lvl  <= run_lvl_d;
      crc      <= crc_d;
      crc_rx   <= crc_rx_d;
      ack_out  <= ack_d;
      rx_valid <= rx_valid_d;
      rx_err   <= rx_err_d;
      err_code <= err_code_d;
      rx_id    <= rx_id_d;
      rx_rtr   <= rx_rtr_d;
      rx_dlc   <= rx_dlc_d;
      rx_data  <= rx_data_d;
      busy     <= busy_d;
    end
  end

  // Frame sequencing and error detection.
  always_comb begin
    state_d    = state;
    err_hit_c  = 1'b0;
    err_kind_c = '0;
    if (sample_en) begin
      case (state)
        S_IDLE:    if (!bit_c) state_d = S_ARB;
        S_ARB: begin
          if (stuff_err_c) begin err_hit_c = 1'b1; err_kind_c = ERR_STUFF; end
          else if (data_bit_c && cnt == CNT_W'(ID_W)) state_d = S_CTRL;
        end
        S_CTRL: begin
          if (stuff_err_c) begin err_hit_c = 1'b1; err_kind_c = ERR_STUFF; end
          else if (data_bit_c && cnt == '0 && bit_c) begin err_hit_c = 1'b1; err_kind_c = ERR_IDE; end
          else if (data_bit_c && cnt == CNT_W'(5))
            state_d = (byte_count(rx_rtr, {rx_dlc[DLC_W-2:0], bit_c}) == '0) ? S_CRC : S_DATA;
        end
        S_DATA: begin
          if (stuff_err_c) begin err_hit_c = 1'b1; err_kind_c = ERR_STUFF; end
          else if (data_bit_c && cnt == last_data_c) state_d = S_CRC;
        end
        S_CRC: begin
          if (stuff_err_c) begin err_hit_c = 1'b1; err_kind_c = ERR_STUFF; end
          else if (data_bit_c && cnt == CNT_W'(CRC_W - 1)) state_d = S_CRC_DEL;
        end
        S_CRC_DEL: begin
          if (stuff_err_c) begin err_hit_c = 1'b1; err_kind_c = ERR_STUFF; end
          else if (!is_stuff_c) begin
            if (!bit_c)             begin err_hit_c = 1'b1; err_kind_c = ERR_FORM; end
            else if (crc_rx != crc) begin err_hit_c = 1'b1; err_kind_c = ERR_CRC;  end
            else                    state_d = S_ACK;
          end
        end
        S_ACK:     state_d = S_ACK_DEL;
        S_ACK_DEL: begin
          if (!bit_c) begin err_hit_c = 1'b1; err_kind_c = ERR_FORM; end
          else        state_d = S_EOF;
        end
        S_EOF: begin
          if (!bit_c)                   begin err_hit_c = 1'b1; err_kind_c = ERR_FORM; end
          else if (cnt == CNT_W'(6))    state_d = S_IDLE;
        end
        S_ERROR:   if (bit_c && cnt == CNT_W'(IDLE_BITS - 1)) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
      if (err_hit_c) state_d = S_ERROR;
    end
  end

  // Counters, CRC, field capture and registered outputs.
  always_comb begin
    cnt_d      = cnt;
    run_cnt_d  = run_cnt;
    run_lvl_d  = run_lvl;
    crc_d      = crc;
    crc_rx_d   = crc_rx;
    ack_d      = ack_out;
    rx_valid_d = 1'b0;
    rx_err_d   = err_hit_c;
    err_code_d = err_code;
    rx_id_d    = rx_id;
    rx_rtr_d   = rx_rtr;
    rx_dlc_d   = rx_dlc;
    rx_data_d  = rx_data;
    busy_d     = (state_d != S_IDLE);
    if (sample_en) begin
      ack_d = 1'b0;
      if (state_d != state)                    cnt_d = '0;
      else if (state == S_ERROR)               cnt_d = bit_c ? cnt + CNT_W'(1) : '0;
      else if (data_bit_c && state != S_IDLE)  cnt_d = cnt + CNT_W'(1);
      if (in_stuff_c) begin
        if (is_stuff_c || bit_c != run_lvl) begin
          run_lvl_d = bit_c;
          run_cnt_d = RUN_W'(1);
        end else begin
          run_cnt_d = run_cnt + RUN_W'(1);
        end
      end
      case (state)
        S_IDLE: if (!bit_c) begin
          run_cnt_d = RUN_W'(1);
          run_lvl_d = 1'b0;
          crc_d     = crc_step('0, 1'b0);
          crc_rx_d  = '0;
          rx_id_d   = '0;
          rx_rtr_d  = 1'b0;
          rx_dlc_d  = '0;
          rx_data_d = '0;
        end
        S_ARB: if (data_bit_c) begin
          crc_d = crc_step(crc, bit_c);
          if (cnt < CNT_W'(ID_W)) rx_id_d = {rx_id[ID_W-2:0], bit_c};
          else                    rx_rtr_d = bit_c;
        end
        S_CTRL: if (data_bit_c) begin
          crc_d = crc_step(crc, bit_c);
          if (cnt >= CNT_W'(2)) rx_dlc_d = {rx_dlc[DLC_W-2:0], bit_c};
        end
        S_DATA: if (data_bit_c) begin
          crc_d     = crc_step(crc, bit_c);
          rx_data_d = rx_data | (DATA_W'(bit_c) << (6'd63 - cnt[5:0]));
        end
        S_CRC:     if (data_bit_c) crc_rx_d = {crc_rx[CRC_W-2:0], bit_c};
        S_CRC_DEL: if (state_d == S_ACK) ack_d = 1'b1;
        S_EOF:     if (state_d == S_IDLE) rx_valid_d = 1'b1;
        default: ;
      endcase
    end
    if (err_hit_c) begin
      err_code_d = err_kind_c;
      ack_d      = 1'b0;
    end else if (rx_valid_d) begin
      err_code_d = '0;
    end
  end
endmodule

// File: tb/tb_can_frame_receiver.sv
// Directed bench for can_frame_receiver: builds stuffed CAN frames with an independent CRC-15
// model, plays them one bit every other clock, and checks decoded fields, ACK and error reporting.
module tb_can_frame_receiver;
  logic        can_clk, reset, sample_en, can_hi_in;
  logic        ack_out, rx_valid, rx_rtr, rx_err, busy;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [2:0]  err_code;

  int tests = 0;
  int fails = 0;
  int n_valid = 0, n_err = 0, n_ack = 0;
  logic        overlap = 1'b0;
  logic [10:0] cap_id;
  logic        cap_rtr;
  logic [3:0]  cap_dlc;
  logic [63:0] cap_data;
  logic        fb[$];
  int          ack_idx;
  logic        ack_seen;

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic        ide;
    logic [3:0]  dlc;
    logic [63:0] data;
    int          drop_stuff;
    int          flip_crc;
    int          eof_dom;
    logic        exp_valid;
    logic        exp_err;
    logic [2:0]  exp_code;
    logic        exp_ack;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  can_frame_receiver dut (
    .can_clk(can_clk), .reset(reset), .sample_en(sample_en), .can_hi_in(can_hi_in),
    .ack_out(ack_out), .rx_valid(rx_valid), .rx_id(rx_id), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data), .rx_err(rx_err), .err_code(err_code), .busy(busy)
  );

  initial can_clk = 1'b0;
  always #5 can_clk = ~can_clk;

  always @(negedge can_clk) begin
    if (rx_valid) begin
      n_valid  <= n_valid + 1;
      cap_id   <= rx_id;
      cap_rtr  <= rx_rtr;
      cap_dlc  <= rx_dlc;
      cap_data <= rx_data;
    end
    if (rx_err)              n_err   <= n_err + 1;
    if (ack_out)             n_ack   <= n_ack + 1;
    if (rx_valid && rx_err)  overlap <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [10:0] id, input logic rtr, input logic ide,
                              input logic [3:0] dlc, input logic [63:0] data, input int drop,
                              input int flip, input int eof, input logic ev, input logic ee,
                              input logic [2:0] ec, input logic ea, input logic [63:0] ed);
    vec_t v;
    v.id = id; v.rtr = rtr; v.ide = ide; v.dlc = dlc; v.data = data;
    v.drop_stuff = drop; v.flip_crc = flip; v.eof_dom = eof;
    v.exp_valid = ev; v.exp_err = ee; v.exp_code = ec; v.exp_ack = ea; v.exp_data = ed;
    return v;
  endfunction

  // Bus bit sequence (logical levels) for one frame plus trailing idle, with optional faults.
  task automatic build(input vec_t v);
    logic       u[$];
    logic [14:0] crc;
    int         nb, run, stuff_no;
    logic       lvl;
    u = {};
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(v.id[i]);
    u.push_back(v.rtr);
    u.push_back(v.ide);
    u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(v.dlc[i]);
    nb = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
    for (int i = 0; i < nb * 8; i++) u.push_back(v.data[63 - i]);
    crc = '0;
    foreach (u[i]) crc = {crc[13:0], 1'b0} ^ ((crc[14] ^ u[i]) ? 15'h4599 : 15'h0000);
    for (int i = 0; i < 15; i++) u.push_back(crc[14 - i] ^ (i == v.flip_crc));
    fb = {};
    run = 0;
    lvl = 1'b0;
    stuff_no = 0;
    foreach (u[i]) begin
      fb.push_back(u[i]);
      if (run > 0 && u[i] == lvl) run++;
      else begin lvl = u[i]; run = 1; end
      if (run == 5) begin
        if (stuff_no != v.drop_stuff) fb.push_back(~lvl);
        stuff_no++;
        lvl = ~lvl;
        run = 1;
      end
    end
    fb.push_back(1'b1);
    ack_idx = fb.size();
    fb.push_back(1'b0);
    fb.push_back(1'b1);
    for (int i = 0; i < 7; i++) fb.push_back((i == v.eof_dom) ? 1'b0 : 1'b1);
    for (int i = 0; i < 12; i++) fb.push_back(1'b1);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge can_clk);
      if (i == ack_idx) ack_seen = ack_out;
      can_hi_in = ~fb[i];
      sample_en = 1'b1;
      @(negedge can_clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge can_clk);
      can_hi_in = 1'b0;
      sample_en = 1'b1;
      @(negedge can_clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int v0, e0, a0;
    v0 = n_valid; e0 = n_err; a0 = n_ack;
    ack_seen = 1'b0;
    build(v);
    send_range(0, fb.size());
    for (int c = 0; c < 64 && busy; c++) @(negedge can_clk);
    check({tag, "_busy"},      64'(busy), 64'(0));
    check({tag, "_valid_cnt"}, 64'(n_valid - v0), 64'(v.exp_valid));
    check({tag, "_err_cnt"},   64'(n_err - e0), 64'(v.exp_err));
    check({tag, "_ack_slot"},  64'(ack_seen), 64'(v.exp_ack));
    check({tag, "_ack_any"},   64'(n_ack != a0), 64'(v.exp_ack));
    check({tag, "_overlap"},   64'(overlap), 64'(0));
    if (v.exp_err) check({tag, "_err_code"}, 64'(err_code), 64'(v.exp_code));
    if (v.exp_valid) begin
      check({tag, "_id"},   64'(cap_id), 64'(v.id));
      check({tag, "_rtr"},  64'(cap_rtr), 64'(v.rtr));
      check({tag, "_dlc"},  64'(cap_dlc), 64'(v.dlc));
      check({tag, "_data"}, cap_data, v.exp_data);
    end
  endtask

  initial begin
    int v0, e0;
    vec_t rv;
    reset = 1'b1;
    sample_en = 1'b0;
    can_hi_in = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge can_clk);
    check("reset_outs", 64'({ack_out, rx_valid, rx_id, rx_rtr, rx_dlc, rx_err, err_code, busy}), 64'(0));
    check("reset_data", rx_data, 64'(0));
    reset = 1'b1;
    send_idle(3);

    vecs[0] = mk(11'h7F8, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000, -1, -1, -1,
                 1'b1, 1'b0, 3'd0, 1'b1, 64'h8900_0000_0000_0000);
    vecs[1] = mk(11'h7F8, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000,  0, -1, -1,
                 1'b0, 1'b1, 3'd1, 1'b0, 64'h0);
    vecs[2] = mk(11'h7F8, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000, -1,  3, -1,
                 1'b0, 1'b1, 3'd2, 1'b0, 64'h0);
    vecs[3] = mk(11'h7FF, 1'b1, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000, -1, -1, -1,
                 1'b1, 1'b0, 3'd0, 1'b1, 64'h0);
    vecs[4] = mk(11'h123, 1'b0, 1'b0, 4'd9, 64'h0102_0304_0506_0708, -1, -1, -1,
                 1'b1, 1'b0, 3'd0, 1'b1, 64'h0102_0304_0506_0708);
    vecs[5] = mk(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1, -1,  2,
                 1'b0, 1'b1, 3'd3, 1'b1, 64'h0);
    vecs[6] = mk(11'h7F8, 1'b0, 1'b1, 4'd1, 64'h8900_0000_0000_0000, -1, -1, -1,
                 1'b0, 1'b1, 3'd4, 1'b0, 64'h0);
    vecs[7] = mk(11'h000, 1'b0, 1'b0, 4'd8, 64'h0, -1, -1, -1,
                 1'b1, 1'b0, 3'd0, 1'b1, 64'h0);
    vecs[8] = mk(11'h555, 1'b0, 1'b0, 4'd3, 64'hFFFF_FF00_0000_0000, -1, -1, -1,
                 1'b1, 1'b0, 3'd0, 1'b1, 64'hFFFF_FF00_0000_0000);

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("v%0d", k));

    // Reset asserted while the receiver is in the middle of the data field.
    rv = mk(11'h2A5, 1'b0, 1'b0, 4'd8, 64'h1122_3344_5566_7788, -1, -1, -1,
            1'b1, 1'b0, 3'd0, 1'b1, 64'h1122_3344_5566_7788);
    v0 = n_valid; e0 = n_err;
    build(rv);
    send_range(0, 40);
    check("pre_reset_busy", 64'(busy), 64'(1));
    #1 reset = 1'b0;
    #1;
    check("midreset_outs", 64'({ack_out, rx_valid, rx_id, rx_rtr, rx_dlc, rx_err, err_code, busy}), 64'(0));
    check("midreset_data", rx_data, 64'(0));
    @(negedge can_clk);
    reset = 1'b1;
    send_idle(15);
    check("midreset_no_valid", 64'(n_valid - v0), 64'(0));
    check("midreset_no_err",   64'(n_err - e0), 64'(0));
    run_vec(rv, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
